// File: rtl/alu_seq_nbit_if.sv
// Operation/result bus of the sequential ALU.
// master = pipeline controller (issues ops, samples results)
// slave  = ALU.
interface alu_seq_nbit_if #(
    parameter int WIDTH = 16
);
    logic             InValid;
    logic             InReady;
    logic [7:0]       OP;
    logic [WIDTH-1:0] FirstOperand;
    logic [WIDTH-1:0] SeconedOperand;
    logic             OutValid;
    logic [WIDTH-1:0] Result;
    logic             ZeroFlag;
    logic             CarryFlag;
    logic             NegativeFlag;
    logic             Error;

    modport master (
        output InValid, OP, FirstOperand, SeconedOperand,
        input  InReady, OutValid, Result, ZeroFlag, CarryFlag, NegativeFlag, Error
    );

    modport slave (
        input  InValid, OP, FirstOperand, SeconedOperand,
        output InReady, OutValid, Result, ZeroFlag, CarryFlag, NegativeFlag, Error
    );
endinterface

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready input handshake.
// Single-cycle ops (ADD/SUB/AND/OR/NOT/SHR/SHL) return one cycle after accept;
// MUL is an unsigned shift-add taking WIDTH steps. Invalid opcodes return
// Result=0 with an Error pulse and leave the flags untouched.
module alu_seq_nbit #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           En,
    alu_seq_nbit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [7:0] OP_ADD = 8'b0000_0001;
    localparam logic [7:0] OP_SUB = 8'b0000_0010;
    localparam logic [7:0] OP_AND = 8'b0000_0100;
    localparam logic [7:0] OP_OR  = 8'b0000_1000;
    localparam logic [7:0] OP_NOT = 8'b0001_0000;
    localparam logic [7:0] OP_SHR = 8'b0010_0000;
    localparam logic [7:0] OP_SHL = 8'b0100_0000;

    logic [0:0]       stateReg;
    logic [CNT_W-1:0] countReg;
    logic [WIDTH-1:0] mcandReg;
    logic [WIDTH-1:0] accHiReg;
    logic [WIDTH-1:0] mplierReg;
    logic [WIDTH-1:0] resultReg;
    logic             zeroReg;
    logic             carryReg;
    logic             negReg;
    logic             outValidReg;
    logic             errorReg;

    logic             accept;
    logic             opValid;
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;
    logic [WIDTH:0]   addFull;
    logic [WIDTH:0]   subFull;
    logic             shiftTooBig;
    logic [WIDTH:0]   stepSum;
    logic [WIDTH-1:0] stepAccHi;
    logic [WIDTH-1:0] stepMplier;

    assign bus.InReady      = (stateReg == IDLE) && En;
    assign bus.OutValid     = outValidReg && En;
    assign bus.Error        = errorReg && En;
    assign bus.Result       = resultReg;
    assign bus.ZeroFlag     = zeroReg;
    assign bus.CarryFlag    = carryReg;
    assign bus.NegativeFlag = negReg;

    assign accept  = bus.InValid && bus.InReady;
    // Exactly one opcode bit set.
    assign opValid = (bus.OP != 8'd0) && ((bus.OP & (bus.OP - 8'd1)) == 8'd0);

    // Single-cycle datapath, evaluated directly on the presented operands.
    always_comb begin
        addFull     = {1'b0, bus.FirstOperand} + {1'b0, bus.SeconedOperand};
        subFull     = {1'b0, bus.FirstOperand} - {1'b0, bus.SeconedOperand};
        shiftTooBig = (bus.SeconedOperand >= WIDTH'(WIDTH));
        aluRes      = '0;
        aluCarry    = 1'b0;
        case (bus.OP)
            OP_ADD: begin aluRes = addFull[WIDTH-1:0]; aluCarry = addFull[WIDTH]; end
            OP_SUB: begin aluRes = subFull[WIDTH-1:0]; aluCarry = subFull[WIDTH]; end
            OP_AND: aluRes = bus.FirstOperand & bus.SeconedOperand;
            OP_OR:  aluRes = bus.FirstOperand | bus.SeconedOperand;
            OP_NOT: aluRes = ~bus.FirstOperand;
            OP_SHR: aluRes = shiftTooBig ? '0 : (bus.FirstOperand >> bus.SeconedOperand);
            OP_SHL: aluRes = shiftTooBig ? '0 : (bus.FirstOperand << bus.SeconedOperand);
            default: aluRes = '0;
        endcase
    end

    // One shift-add step on the {accHi, mplier} product register.
    always_comb begin
        stepSum    = {1'b0, accHiReg} + {1'b0, (mplierReg[0] ? mcandReg : {WIDTH{1'b0}})};
        stepAccHi  = stepSum[WIDTH:1];
        stepMplier = {stepSum[0], mplierReg[WIDTH-1:1]};
    end

    // Control FSM, multiply datapath and registered outputs; En low freezes all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            countReg    <= '0;
            mcandReg    <= '0;
            accHiReg    <= '0;
            mplierReg   <= '0;
            resultReg   <= '0;
            zeroReg     <= 1'b0;
            carryReg    <= 1'b0;
            negReg      <= 1'b0;
            outValidReg <= 1'b0;
            errorReg    <= 1'b0;
        end else if (En) begin
            outValidReg <= 1'b0;
            errorReg    <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        if (!opValid) begin
                            resultReg   <= '0;
                            outValidReg <= 1'b1;
                            errorReg    <= 1'b1;
                        end else if (bus.OP[7]) begin
                            stateReg  <= BUSY;
                            countReg  <= CNT_W'(WIDTH);
                            accHiReg  <= '0;
                            mcandReg  <= bus.FirstOperand;
                            mplierReg <= bus.SeconedOperand;
                        end else begin
                            resultReg   <= aluRes;
                            zeroReg     <= (aluRes == '0);
                            carryReg    <= aluCarry;
                            negReg      <= aluRes[WIDTH-1];
                            outValidReg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    accHiReg  <= stepAccHi;
                    mplierReg <= stepMplier;
                    countReg  <= countReg - CNT_W'(1);
                    // Last step: the stepped value is the full product.
                    if (countReg == CNT_W'(1)) begin
                        stateReg    <= IDLE;
                        resultReg   <= stepMplier;
                        zeroReg     <= (stepMplier == '0);
                        carryReg    <= |stepAccHi;
                        negReg      <= stepMplier[WIDTH-1];
                        outValidReg <= 1'b1;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed testbench for alu_seq_nbit (WIDTH=16).
module tb_alu_seq_nbit;
    logic clk;
    logic rst_n;
    logic En;
    int   total = 0;
    int   bad   = 0;

    alu_seq_nbit_if #(.WIDTH(16)) bus ();

    alu_seq_nbit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .En    (En),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic checkOuts(input string tag, input logic [15:0] res,
                             input logic z, input logic c, input logic n, input logic err);
        checkVal({tag, "_res"}, 32'(bus.Result), 32'(res));
        checkVal({tag, "_z"},   32'(bus.ZeroFlag), 32'(z));
        checkVal({tag, "_c"},   32'(bus.CarryFlag), 32'(c));
        checkVal({tag, "_n"},   32'(bus.NegativeFlag), 32'(n));
        checkVal({tag, "_err"}, 32'(bus.Error), 32'(err));
    endtask

    // Issue at a negedge, then count negedges until OutValid. Optionally
    // drops En for three cycles after the dropAt-th negedge.
    task automatic runOp(input string tag, input logic [7:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input int expLat, input int expBusy, input int dropAt,
                         input logic [15:0] res, input logic z, input logic c,
                         input logic n, input logic err);
        int lat;
        int busy;
        lat  = 0;
        busy = 0;
        checkVal({tag, "_rdy"}, 32'(bus.InReady), 32'd1);
        bus.OP             = op;
        bus.FirstOperand   = a;
        bus.SeconedOperand = b;
        bus.InValid        = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.OutValid || lat >= 200) break;
            if (!bus.InReady) busy++;
            if (dropAt != 0 && lat == dropAt) En = 1'b0;
            if (dropAt != 0 && lat == dropAt + 3) En = 1'b1;
        end
        checkVal({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkVal({tag, "_busy"}, 32'(busy), 32'(expBusy));
        checkOuts(tag, res, z, c, n, err);
    endtask

    initial begin
        int ovCount;
        rst_n = 1'b0;
        En    = 1'b1;
        bus.InValid        = 1'b0;
        bus.OP             = 8'd0;
        bus.FirstOperand   = '0;
        bus.SeconedOperand = '0;

        // Reset state.
        @(negedge clk);
        checkVal("rst_ov", 32'(bus.OutValid), 32'd0);
        checkOuts("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("add_ovf", 8'h01, 16'hFFFF, 16'h0001, 1, 0, 0, 16'h0000, 1, 1, 0, 0);

        // SUB followed back-to-back by AND while SUB's OutValid is high.
        @(negedge clk);
        bus.OP = 8'h02; bus.FirstOperand = 16'h0003; bus.SeconedOperand = 16'h0005;
        bus.InValid = 1'b1;
        @(posedge clk);
        #1;
        bus.OP = 8'h04; bus.FirstOperand = 16'hF0F0; bus.SeconedOperand = 16'h0FF0;
        @(negedge clk);
        checkVal("sub_ov", 32'(bus.OutValid), 32'd1);
        checkVal("sub_rdy", 32'(bus.InReady), 32'd1);
        checkOuts("sub", 16'hFFFE, 0, 1, 1, 0);
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        @(negedge clk);
        checkVal("and_ov", 32'(bus.OutValid), 32'd1);
        checkOuts("and", 16'h00F0, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("and_ov_drop", 32'(bus.OutValid), 32'd0);

        runOp("or",    8'h08, 16'h0F00, 16'h00F0, 1, 0, 0, 16'h0FF0, 0, 0, 0, 0);
        runOp("mul1",  8'h80, 16'h0100, 16'h0101, 17, 16, 0, 16'h0100, 0, 1, 0, 0);
        runOp("mul2",  8'h80, 16'h00FF, 16'h0002, 17, 16, 0, 16'h01FE, 0, 0, 0, 0);
        runOp("not",   8'h10, 16'h00FF, 16'h0000, 1, 0, 0, 16'hFF00, 0, 0, 1, 0);
        runOp("shr15", 8'h20, 16'h8000, 16'd15, 1, 0, 0, 16'h0001, 0, 0, 0, 0);
        runOp("shl16", 8'h40, 16'h0001, 16'd16, 1, 0, 0, 16'h0000, 1, 0, 0, 0);
        runOp("badop", 8'h03, 16'h1234, 16'h5678, 1, 0, 0, 16'h0000, 1, 0, 0, 1);
        runOp("mul_en", 8'h80, 16'h1234, 16'h0010, 20, 19, 5, 16'h2340, 0, 1, 0, 0);

        // Reset during a MUL: outputs clear at once, product never appears.
        bus.OP = 8'h80; bus.FirstOperand = 16'h0003; bus.SeconedOperand = 16'h0003;
        bus.InValid = 1'b1;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("rstmid_ov", 32'(bus.OutValid), 32'd0);
        checkOuts("rstmid", 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ovCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.OutValid) ovCount++;
        end
        checkVal("rstmid_noov", 32'(ovCount), 32'd0);

        runOp("add_post", 8'h01, 16'h0002, 16'h0003, 1, 0, 0, 16'h0005, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
